mu0_mem_arbiter: RTL and testbench

MU0_MEM_ARBITER -- requirements
Module: mu0_mem_arbiter

---
 rtl/mu0_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mu0_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single shared memory.
// Each access takes three cycles: IDLE picks and latches a winner,
// ACCESS strobes the memory, and RESP acknowledges the granted port.
module mu0_mem_arbiter #(
    parameter int ADDR = 12,
    parameter int DATA = 16
) (
    input  logic            clk,
    input  logic            rst,
    // port 0 (CPU)
    input  logic            req0,
    input  logic            rnw0,
    input  logic [ADDR-1:0] addr0,
    input  logic [DATA-1:0] wdata0,
    output logic            ack0,
    output logic [DATA-1:0] rdata0,
    // port 1 (loader/debug)
    input  logic            req1,
    input  logic            rnw1,
    input  logic [ADDR-1:0] addr1,
    input  logic [DATA-1:0] wdata1,
    output logic            ack1,
    output logic [DATA-1:0] rdata1,
    // memory side
    output logic            mem_rq,
    output logic            mem_rnw,
    output logic [ADDR-1:0] mem_addr,
    inout  wire  [DATA-1:0] databus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            ptr;        // port that wins when both request
    logic            gid;        // port granted for the access in flight
    logic            lat_rnw;
    logic [ADDR-1:0] lat_addr;
    logic [DATA-1:0] lat_wdata;
    logic            win;
    logic            start;

    // Winner selection: a lone requester wins, otherwise the pointer decides.
    always_comb begin
        win   = (req0 && req1) ? ptr : req1;
        start = (state == IDLE) && (req0 || req1);
    end

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and decoded outputs for the three-phase access.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_nxt = state;
        mem_rq    = 1'b0;
        mem_rnw   = 1'b1;
        mem_addr  = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = RESP;
                mem_rq    = 1'b1;
                mem_rnw   = lat_rnw;
                mem_addr  = lat_addr;
            end
            RESP: begin
                state_nxt = IDLE;
                ack0      = ~gid;
                ack1      = gid;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's request at the IDLE->ACCESS edge and rotate priority
    // to the loser, so later input changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= 1'b0;
            gid       <= 1'b0;
            lat_rnw   <= 1'b1;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (start) begin
            ptr       <= ~win;
            gid       <= win;
            lat_rnw   <= win ? rnw1   : rnw0;
            lat_addr  <= win ? addr1  : addr0;
            lat_wdata <= win ? wdata1 : wdata0;
        end
    end

    // Read data capture at the ACCESS->RESP edge; held until that port's
    // next read completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == ACCESS && lat_rnw) begin
            if (gid) rdata1 <= databus;
            else     rdata0 <= databus;
        end
    end

    // The arbiter only drives the shared bus while strobing a write.
    assign databus = (state == ACCESS && !lat_rnw) ? lat_wdata : 'z;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Self-checking bench for mu0_mem_arbiter: a memory model on the shared bus,
// a transaction-level reference model compared every cycle, and directed
// scenarios with hand-computed expectations.
module tb_mu0_mem_arbiter;

    localparam int ADDR = 12;
    localparam int DATA = 16;
    localparam logic [DATA-1:0] BUS_IDLE = 16'hFFFF;  // pulled-up, undriven bus

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req0 = 1'b0, rnw0 = 1'b1, req1 = 1'b0, rnw1 = 1'b1;
    logic [ADDR-1:0] addr0 = '0, addr1 = '0;
    logic [DATA-1:0] wdata0 = '0, wdata1 = '0;
    logic            ack0, ack1, mem_rq, mem_rnw;
    logic [DATA-1:0] rdata0, rdata1;
    logic [ADDR-1:0] mem_addr;
    wire  [DATA-1:0] databus;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mu0_mem_arbiter #(.ADDR(ADDR), .DATA(DATA)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .rnw0(rnw0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .rnw1(rnw1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .mem_rq(mem_rq), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
        .databus(databus)
    );

    pullup bus_pu (databus);

    // Environment memory: answers reads on the bus, stores strobed writes.
    logic [DATA-1:0] ram [4096];
    assign databus = (mem_rq && mem_rnw) ? ram[mem_addr] : 'z;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = DATA'(i) ^ 16'hC3C3;
        forever begin
            @(posedge clk);
            if (mem_rq && !mem_rnw) ram[mem_addr] <= databus;
        end
    end

    // Reference model: one transaction record with an age in cycles.
    logic            model_on = 1'b0;
    logic            m_busy = 1'b0;
    int              m_age = 0;
    logic            m_ptr = 1'b0, m_port = 1'b0, m_rnw = 1'b1;
    logic [ADDR-1:0] m_addr = '0;
    logic [DATA-1:0] m_wdata = '0, m_rd0 = '0, m_rd1 = '0;
    logic [DATA-1:0] mmem [4096];

    initial begin
        for (int i = 0; i < 4096; i++) mmem[i] = DATA'(i) ^ 16'hC3C3;
        forever begin
            @(posedge clk);
            if (!rst) begin
                // a write strobed in this cycle still lands in memory
                if (m_busy && m_age == 1 && !m_rnw) mmem[m_addr] <= m_wdata;
                m_busy   <= 1'b0;
                m_age    <= 0;
                m_ptr    <= 1'b0;
                m_rd0    <= '0;
                m_rd1    <= '0;
                model_on <= 1'b1;
            end else if (model_on) begin
                if (!m_busy) begin
                    if (req0 || req1) begin
                        m_port  <= (req0 && req1) ? m_ptr : req1;
                        m_ptr   <= (req0 && req1) ? ~m_ptr : ~req1;
                        m_rnw   <= req1 && !(req0 && !m_ptr) ? rnw1 : rnw0;
                        m_addr  <= req1 && !(req0 && !m_ptr) ? addr1 : addr0;
                        m_wdata <= req1 && !(req0 && !m_ptr) ? wdata1 : wdata0;
                        m_busy  <= 1'b1;
                        m_age   <= 1;
                    end
                end else if (m_age == 1) begin
                    if (!m_rnw)      mmem[m_addr] <= m_wdata;
                    else if (m_port) m_rd1 <= mmem[m_addr];
                    else             m_rd0 <= mmem[m_addr];
                    m_age <= 2;
                end else begin
                    m_busy <= 1'b0;
                    m_age  <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the reference model.
    logic            e_rq;
    logic [DATA-1:0] e_bus;
    always @(negedge clk) begin
        if (model_on) begin
            e_rq  = m_busy && m_age == 1;
            e_bus = !e_rq ? BUS_IDLE : (m_rnw ? mmem[m_addr] : m_wdata);
            check("cyc_mem_rq",   32'(mem_rq),   32'(e_rq));
            check("cyc_mem_rnw",  32'(mem_rnw),  32'(e_rq ? m_rnw : 1'b1));
            check("cyc_mem_addr", 32'(mem_addr), 32'(e_rq ? m_addr : '0));
            check("cyc_ack0",     32'(ack0),     32'(m_busy && m_age == 2 && !m_port));
            check("cyc_ack1",     32'(ack1),     32'(m_busy && m_age == 2 && m_port));
            check("cyc_rdata0",   32'(rdata0),   32'(m_rd0));
            check("cyc_rdata1",   32'(rdata1),   32'(m_rd1));
            check("cyc_databus",  32'(databus),  32'(e_bus));
        end
    end

    int n_ack;
    int ack_port [4];
    int ack_cyc  [4];
    logic seen;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("rst_mem_rq",   32'(mem_rq),   32'h0);
        check("rst_mem_rnw",  32'(mem_rnw),  32'h1);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_acks",     32'({ack0, ack1}), 32'h0);
        check("rst_rdata",    32'({rdata0, rdata1}), 32'h0);
        check("rst_databus",  32'(databus),  32'(BUS_IDLE));

        // port-0 write of A5A5 to address 5
        req0 = 1'b1; rnw0 = 1'b0; addr0 = 12'd5; wdata0 = 16'hA5A5;
        @(negedge clk);
        check("wr_mem_rq",   32'(mem_rq),   32'h1);
        check("wr_mem_rnw",  32'(mem_rnw),  32'h0);
        check("wr_mem_addr", 32'(mem_addr), 32'h5);
        check("wr_databus",  32'(databus),  32'hA5A5);
        check("wr_no_ack_yet", 32'(ack0),   32'h0);
        @(negedge clk);
        check("wr_ack0", 32'(ack0), 32'h1);
        req0 = 1'b0;
        @(negedge clk);

        // port-1 read of address 5; wdata1 is junk the arbiter must not drive
        req1 = 1'b1; rnw1 = 1'b1; addr1 = 12'd5; wdata1 = 16'h0F0F;
        @(negedge clk);
        check("rd1_mem_rnw", 32'(mem_rnw), 32'h1);
        check("rd1_databus", 32'(databus), 32'hA5A5);
        @(negedge clk);
        check("rd1_ack1",   32'(ack1),   32'h1);
        check("rd1_ack0",   32'(ack0),   32'h0);
        check("rd1_rdata1", 32'(rdata1), 32'hA5A5);
        req1 = 1'b0;
        @(negedge clk);

        // address change mid-access: address 3 must be the one read
        req0 = 1'b1; rnw0 = 1'b1; addr0 = 12'd3;
        @(negedge clk);
        check("chg_mem_addr_a", 32'(mem_addr), 32'h3);
        addr0 = 12'd7;
        @(negedge clk);
        check("chg_mem_addr_b", 32'(mem_addr), 32'h0);
        check("chg_ack0",   32'(ack0),   32'h1);
        check("chg_rdata0", 32'(rdata0), 32'hC3C0);
        check("chg_rdata1_held", 32'(rdata1), 32'hA5A5);
        req0 = 1'b0;
        @(negedge clk);

        // reset during a port-1 read, before its ack can appear
        req1 = 1'b1; rnw1 = 1'b1; addr1 = 12'd7;
        @(negedge clk);
        check("rr_mem_rq", 32'(mem_rq), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check("rr_ack1",    32'(ack1),    32'h0);
        check("rr_ack0",    32'(ack0),    32'h0);
        check("rr_mem_rq0", 32'(mem_rq),  32'h0);
        check("rr_rdata1",  32'(rdata1),  32'h0);
        check("rr_databus", 32'(databus), 32'(BUS_IDLE));
        // both request after reset: port 0 must win
        rst = 1'b1; req0 = 1'b1; rnw0 = 1'b1; addr0 = 12'd9;
        @(negedge clk);
        check("rr_p0_wins_addr", 32'(mem_addr), 32'h9);
        @(negedge clk);
        check("rr_p0_ack",   32'(ack0),   32'h1);
        check("rr_p0_rdata", 32'(rdata0), 32'hC3CA);
        req0 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = ack1;
        end
        check("rr_p1_served", 32'(seen), 32'h1);
        check("rr_p1_rdata",  32'(rdata1), 32'hC3C4);
        req1 = 1'b0;
        @(negedge clk);

        // a write strobed when reset arrives still reaches memory
        req0 = 1'b1; rnw0 = 1'b0; addr0 = 12'd20; wdata0 = 16'h1234;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("wrst_no_ack", 32'({ack0, ack1}), 32'h0);
        rst = 1'b1; rnw0 = 1'b1;
        repeat (2) @(negedge clk);
        check("wrst_ack0",   32'(ack0),   32'h1);
        check("wrst_rdata0", 32'(rdata0), 32'h1234);
        req0 = 1'b0;

        // contention from reset: grants alternate, one ack every 3 cycles
        rst = 1'b0;
        req0 = 1'b1; rnw0 = 1'b1; addr0 = 12'd10;
        req1 = 1'b1; rnw1 = 1'b1; addr1 = 12'd11;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 20 && n_ack < 4; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                ack_port[n_ack] = int'(ack1);
                ack_cyc[n_ack]  = c;
                n_ack++;
            end
        end
        check("cont_ack_count", 32'(n_ack), 32'd4);
        if (n_ack > 0) check("cont_first_latency", 32'(ack_cyc[0]), 32'd1);
        for (int i = 0; i < n_ack; i++) begin
            check("cont_grant_order", 32'(ack_port[i]), 32'(i % 2));
            if (i > 0) check("cont_ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end
        check("cont_rdata0", 32'(rdata0), 32'hC3C9);
        check("cont_rdata1", 32'(rdata1), 32'hC3C8);
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
